// File: rtl/cnn_stream_packer.sv
// cnn_stream_packer: packs signed CNN activations into a 32-bit stream with
// frame markers. A small first-word fall-through FIFO absorbs downstream
// stalls; the upstream cannot be stalled, so overflowing samples are dropped
// while the frame sample counter keeps running to preserve alignment.
module cnn_stream_packer #(
  parameter int DATA_WIDTH = 20,
  parameter int FRAME_LEN  = 3600,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  input  logic                  in_done,
  output logic [31:0]           m_tdata,
  output logic                  m_tvalid,
  input  logic                  m_tready,
  output logic                  m_tlast,
  output logic                  overflow,
  output logic                  frame_err,
  output logic                  busy
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam logic [AW:0]   FULL_CNT = (AW+1)'(FIFO_DEPTH);
  localparam logic [CW-1:0] LAST_CNT = CW'(FRAME_LEN - 1);

  typedef enum logic [1:0] {IDLE, ACTIVE, DRAIN} state_t;

  logic [1:0]    rst_sync_q;
  logic          rst_n;
  logic [32:0]   mem_q [FIFO_DEPTH];
  logic [AW-1:0] wptr_q, rptr_q;
  logic [AW:0]   count_q;
  logic [CW-1:0] cnt_q, cnt_d;
  state_t        state_q;
  logic          overflow_q, frame_err_q, lost_last_q;

  logic          empty, full, pop, push, drop, is_last, tlast_pop, done_err;
  logic [32:0]   head;
  logic [31:0]   ext_data;

  // Reset asserts asynchronously and releases on a clock edge
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) rst_sync_q <= '0;
    else        rst_sync_q <= {rst_sync_q[0], 1'b1};
  end

  assign rst_n = rst_sync_q[1];

  // FIFO handshake decode, frame position and alignment check
  always_comb begin
    ext_data  = 32'(signed'(in_data));
    empty     = (count_q == '0);
    full      = (count_q == FULL_CNT);
    pop       = !empty && m_tready;
    push      = in_valid && (!full || pop);
    drop      = in_valid && full && !pop;
    is_last   = (cnt_q == LAST_CNT);
    head      = mem_q[rptr_q];
    tlast_pop = pop && head[32];
    done_err  = in_done && (cnt_q != '0) && !(in_valid && is_last);
    cnt_d     = cnt_q;
    if (in_valid) cnt_d = is_last ? '0 : cnt_q + 1'b1;
  end

  // FIFO storage, written at the tail; no reset needed as occupancy gates use
  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= {is_last, ext_data};
  end

  // Pointers, occupancy, frame counter, sticky flags and the frame FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q      <= '0;
      rptr_q      <= '0;
      count_q     <= '0;
      cnt_q       <= '0;
      state_q     <= IDLE;
      overflow_q  <= 1'b0;
      frame_err_q <= 1'b0;
      lost_last_q <= 1'b0;
    end else begin
      if (push) wptr_q <= wptr_q + 1'b1;
      if (pop)  rptr_q <= rptr_q + 1'b1;
      count_q <= count_q + (AW+1)'(push) - (AW+1)'(pop);
      cnt_q   <= cnt_d;
      if (drop)            overflow_q  <= 1'b1;
      if (drop && is_last) lost_last_q <= 1'b1;
      if (done_err)        frame_err_q <= 1'b1;
      case (state_q)
        IDLE:   if (in_valid) state_q <= is_last ? DRAIN : ACTIVE;
        ACTIVE: if (in_valid && is_last) state_q <= DRAIN;
        DRAIN: begin
          // A lost frame end can never be handshaked, so DRAIN is held.
          // If the next frame's end arrives on the same cycle the current
          // end leaves, stay in DRAIN rather than passing through ACTIVE.
          if (tlast_pop && !lost_last_q) begin
            if (in_valid && is_last) state_q <= DRAIN;
            else if (cnt_d != '0)    state_q <= ACTIVE;
            else                     state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign m_tvalid  = !empty;
  assign m_tdata   = empty ? '0 : head[31:0];
  assign m_tlast   = !empty && head[32];
  assign overflow  = overflow_q;
  assign frame_err = frame_err_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_cnn_stream_packer.sv
// Bench for cnn_stream_packer with FRAME_LEN=4, FIFO_DEPTH=4. A negedge
// monitor models FIFO acceptance into a scoreboard queue and checks every
// stream output against its head; directed steps check flags and beats.
module tb_cnn_stream_packer;

  logic        clk = 1'b0;
  logic        reset;
  logic [19:0] in_data;
  logic        in_valid, in_done, m_tready;
  logic [31:0] m_tdata;
  logic        m_tvalid, m_tlast, overflow, frame_err, busy;

  int checks = 0;
  int errors = 0;

  logic [32:0] sb [$];
  logic [31:0] beat_data [$];
  logic        beat_last [$];
  int          mcnt = 0;

  cnn_stream_packer #(.DATA_WIDTH(20), .FRAME_LEN(4), .FIFO_DEPTH(4)) dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
    .in_done(in_done), .m_tdata(m_tdata), .m_tvalid(m_tvalid),
    .m_tready(m_tready), .m_tlast(m_tlast), .overflow(overflow),
    .frame_err(frame_err), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [32:0] obs, input logic [32:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Scoreboard: compare head, record beats, then model this cycle's push
  always @(negedge clk) begin
    if (!reset) begin
      sb.delete();
      mcnt = 0;
    end else begin
      logic was_full, pop_m;
      chk("tvalid", {32'b0, m_tvalid}, {32'b0, sb.size() != 0});
      if (sb.size() != 0) begin
        chk("tdata", {1'b0, m_tdata}, {1'b0, sb[0][31:0]});
        chk("tlast", {32'b0, m_tlast}, {32'b0, sb[0][32]});
      end
      was_full = (sb.size() == 4);
      pop_m    = (sb.size() != 0) && m_tready;
      if (pop_m) begin
        beat_data.push_back(m_tdata);
        beat_last.push_back(m_tlast);
        void'(sb.pop_front());
      end
      if (in_valid) begin
        if (!was_full || pop_m) sb.push_back({mcnt == 3, 32'(signed'(in_data))});
        mcnt = (mcnt == 3) ? 0 : mcnt + 1;
      end
    end
  end

  task automatic step(input logic v, input logic [19:0] d, input logic dn, input logic rdy);
    @(posedge clk);
    #1;
    in_valid = v;
    in_data  = d;
    in_done  = dn;
    m_tready = rdy;
  endtask

  task automatic clear_beats();
    beat_data.delete();
    beat_last.delete();
  endtask

  task automatic check_reset_outputs();
    chk("rst_tvalid", {32'b0, m_tvalid}, 33'd0);
    chk("rst_tlast", {32'b0, m_tlast}, 33'd0);
    chk("rst_tdata", {1'b0, m_tdata}, 33'd0);
    chk("rst_busy", {32'b0, busy}, 33'd0);
    chk("rst_overflow", {32'b0, overflow}, 33'd0);
    chk("rst_frame_err", {32'b0, frame_err}, 33'd0);
  endtask

  task automatic release_rst();
    @(posedge clk);
    #2 reset = 1'b1;
    repeat (3) @(posedge clk);
  endtask

  // Asynchronous assertion in the middle of the clock high phase
  task automatic pulse_rst();
    @(posedge clk);
    #3 reset = 1'b0;
    #1 check_reset_outputs();
    in_valid = 1'b0;
    in_done  = 1'b0;
    repeat (2) @(posedge clk);
    release_rst();
  endtask

  initial begin
    int nlast;
    reset    = 1'b0;
    in_data  = '0;
    in_valid = 1'b0;
    in_done  = 1'b0;
    m_tready = 1'b0;
    repeat (3) @(posedge clk);
    #1 check_reset_outputs();
    release_rst();

    // Basic frame with sign extension, downstream always ready
    clear_beats();
    step(1, 20'h00001, 0, 1);
    step(1, 20'hFFFFF, 0, 1);
    chk("t1_busy_mid", {32'b0, busy}, 33'd1);
    step(1, 20'h7FFFF, 0, 1);
    step(1, 20'h80000, 0, 1);
    step(0, '0, 0, 1);
    step(0, '0, 0, 1);
    chk("t1_nbeats", beat_data.size(), 33'd4);
    chk("t1_beat0", {1'b0, beat_data[0]}, {1'b0, 32'h00000001});
    chk("t1_beat1", {1'b0, beat_data[1]}, {1'b0, 32'hFFFFFFFF});
    chk("t1_beat2", {1'b0, beat_data[2]}, {1'b0, 32'h0007FFFF});
    chk("t1_beat3", {1'b0, beat_data[3]}, {1'b0, 32'hFFF80000});
    chk("t1_last", {29'b0, beat_last[0], beat_last[1], beat_last[2], beat_last[3]}, 33'b0001);
    chk("t1_busy_end", {32'b0, busy}, 33'd0);

    // Backpressure: four held, fifth dropped
    pulse_rst();
    clear_beats();
    for (int i = 0; i < 5; i++) step(1, 20'h00010 + 20'(i), 0, 0);
    step(0, '0, 0, 0);
    step(0, '0, 0, 0);
    chk("t2_overflow", {32'b0, overflow}, 33'd1);
    chk("t2_no_beats", beat_data.size(), 33'd0);
    chk("t2_held_valid", {32'b0, m_tvalid}, 33'd1);
    for (int i = 0; i < 6; i++) step(0, '0, 0, 1);
    chk("t2_nbeats", beat_data.size(), 33'd4);
    chk("t2_last", {29'b0, beat_last[0], beat_last[1], beat_last[2], beat_last[3]}, 33'b0001);
    chk("t2_busy_next_frame", {32'b0, busy}, 33'd1);

    // Full FIFO with simultaneous pop accepts the push
    pulse_rst();
    clear_beats();
    for (int i = 0; i < 4; i++) step(1, 20'hFFFF0 + 20'(i), 0, 0);
    step(1, 20'h12345, 0, 1);
    step(0, '0, 0, 0);
    chk("t3_no_overflow", {32'b0, overflow}, 33'd0);
    chk("t3_one_beat", beat_data.size(), 33'd1);
    step(1, 20'h54321, 0, 0);
    step(0, '0, 0, 0);
    chk("t3_still_full", {32'b0, overflow}, 33'd1);
    for (int i = 0; i < 6; i++) step(0, '0, 0, 1);
    chk("t3_nbeats", beat_data.size(), 33'd5);
    chk("t3_beat0", {1'b0, beat_data[0]}, {1'b0, 32'hFFFFFFF0});
    chk("t3_beat4", {1'b0, beat_data[4]}, {1'b0, 32'h00012345});
    chk("t3_last", {28'b0, beat_last[0], beat_last[1], beat_last[2], beat_last[3], beat_last[4]}, 33'b00010);

    // Back-to-back frames with toggling ready
    pulse_rst();
    clear_beats();
    for (int i = 0; i < 8; i++) begin
      step(1, 20'(i * 3 + 1), 0, 1'(i % 2));
      if (i == 5) chk("t4_busy_mid", {32'b0, busy}, 33'd1);
    end
    for (int i = 8; i < 20; i++) step(0, '0, 0, 1'(i % 2));
    nlast = 0;
    foreach (beat_last[i]) if (beat_last[i]) nlast++;
    chk("t4_nbeats", beat_data.size(), 33'd8);
    chk("t4_last3", {32'b0, beat_last[3]}, 33'd1);
    chk("t4_last7", {32'b0, beat_last[7]}, 33'd1);
    chk("t4_nlast", nlast, 33'd2);
    chk("t4_overflow", {32'b0, overflow}, 33'd0);
    chk("t4_busy_end", {32'b0, busy}, 33'd0);

    // in_done alignment checking
    pulse_rst();
    for (int i = 0; i < 3; i++) step(1, 20'(i), 0, 1);
    step(1, 20'h3, 1, 1);
    step(0, '0, 0, 1);
    chk("t5_done_aligned", {32'b0, frame_err}, 33'd0);
    step(1, 20'h4, 0, 1);
    step(1, 20'h5, 0, 1);
    step(0, '0, 1, 1);
    step(0, '0, 0, 1);
    chk("t5_done_misaligned", {32'b0, frame_err}, 33'd1);
    step(1, 20'h6, 0, 1);
    step(1, 20'h7, 0, 1);
    for (int i = 0; i < 3; i++) step(0, '0, 0, 1);
    chk("t5_sticky", {32'b0, frame_err}, 33'd1);

    // Mid-clock reset with three entries queued, then a clean frame
    for (int i = 0; i < 3; i++) step(1, 20'h00100 + 20'(i), 0, 0);
    step(0, '0, 0, 0);
    chk("t6_queued", {32'b0, m_tvalid}, 33'd1);
    pulse_rst();
    clear_beats();
    step(1, 20'hABCDE, 0, 1);
    step(1, 20'h01234, 0, 1);
    step(1, 20'h00002, 0, 1);
    step(1, 20'h00003, 0, 1);
    for (int i = 0; i < 3; i++) step(0, '0, 0, 1);
    chk("t6_nbeats", beat_data.size(), 33'd4);
    chk("t6_beat0", {1'b0, beat_data[0]}, {1'b0, 32'hFFFABCDE});
    chk("t6_last", {29'b0, beat_last[0], beat_last[1], beat_last[2], beat_last[3]}, 33'b0001);
    chk("t6_busy_end", {32'b0, busy}, 33'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
